// File: rtl/fifo_consumer_if.sv
// FIFO read-port bundle between a consumer and the async FIFO read side.
// Ports: O_RD_EN (read strobe), I_EMPTY (sync empty flag), I_DATA (read word).
interface fifo_consumer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  O_RD_EN;
    logic                  I_EMPTY;
    logic [DATA_WIDTH-1:0] I_DATA;

    modport master (
        output O_RD_EN,
        input  I_EMPTY,
        input  I_DATA
    );

    modport slave (
        input  O_RD_EN,
        output I_EMPTY,
        output I_DATA
    );
endinterface

// File: rtl/fifo_consumer.sv
// Paced FIFO drain that captures each word and checks an incrementing sequence.
// Ports: CON_CLK/CON_RST, ENABLE, PACE, rd (FIFO read port), O_DATA*, counters.
module fifo_consumer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    PACE_WIDTH  = 4,
    parameter int                    COUNT_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] EXP_INIT    = '0
) (
    input  logic                   CON_CLK,
    input  logic                   CON_RST,
    input  logic                   ENABLE,
    input  logic [PACE_WIDTH-1:0]  PACE,
    fifo_consumer_if.master        rd,
    output logic                   O_DATA_VALID,
    output logic [DATA_WIDTH-1:0]  O_DATA,
    output logic                   O_MISMATCH,
    output logic [COUNT_WIDTH-1:0] RD_COUNT,
    output logic [COUNT_WIDTH-1:0] ERR_COUNT
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PACE_WIDTH-1:0]  pace_cnt_q;
    logic [PACE_WIDTH-1:0]  pace_cnt_d;
    logic                   rd_en;

    logic                   rd_pend_q;
    logic                   rd_pend_d;
    logic                   valid_q;
    logic                   valid_d;
    logic                   mismatch_q;
    logic                   mismatch_d;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [DATA_WIDTH-1:0]  data_d;
    logic [DATA_WIDTH-1:0]  exp_q;
    logic [DATA_WIDTH-1:0]  exp_d;
    logic [COUNT_WIDTH-1:0] rd_cnt_q;
    logic [COUNT_WIDTH-1:0] rd_cnt_d;
    logic [COUNT_WIDTH-1:0] err_cnt_q;
    logic [COUNT_WIDTH-1:0] err_cnt_d;

    // FSM state register
    always_ff @(posedge CON_CLK or posedge CON_RST) begin
        if (CON_RST) begin
            state_q    <= IDLE;
            pace_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pace_cnt_q <= pace_cnt_d;
        end
    end

    // FSM next state; PACE is only looked at on the read cycle
    always_comb begin
        state_d    = state_q;
        pace_cnt_d = pace_cnt_q;
        if (!ENABLE) begin
            state_d    = IDLE;
            pace_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = READ;
                READ: begin
                    if (rd_en && (PACE != '0)) begin
                        state_d    = WAIT;
                        pace_cnt_d = PACE;
                    end
                end
                WAIT: begin
                    pace_cnt_d = pace_cnt_q - 1'b1;
                    if (pace_cnt_q == PACE_WIDTH'(1)) begin
                        state_d = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: the empty gate keeps the FIFO from underflowing
    always_comb begin
        rd_en = (state_q == READ) && ENABLE && !rd.I_EMPTY;
    end

    assign rd.O_RD_EN = rd_en;

    // Capture/check: rd_pend_q marks the cycle I_DATA carries a read word
    always_comb begin
        rd_pend_d  = rd_en;
        valid_d    = rd_pend_q;
        mismatch_d = rd_pend_q && (rd.I_DATA != exp_q);
        data_d     = data_q;
        exp_d      = exp_q;
        rd_cnt_d   = rd_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (rd_pend_q) begin
            data_d   = rd.I_DATA;
            // Resync on every word so one bad word costs exactly one error
            exp_d    = rd.I_DATA + 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (mismatch_d && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CON_CLK or posedge CON_RST) begin
        if (CON_RST) begin
            rd_pend_q  <= 1'b0;
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
            data_q     <= '0;
            exp_q      <= EXP_INIT;
            rd_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            valid_q    <= valid_d;
            mismatch_q <= mismatch_d;
            data_q     <= data_d;
            exp_q      <= exp_d;
            rd_cnt_q   <= rd_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign O_DATA_VALID = valid_q;
    assign O_DATA       = data_q;
    assign O_MISMATCH   = mismatch_q;
    assign RD_COUNT     = rd_cnt_q;
    assign ERR_COUNT    = err_cnt_q;

endmodule

// File: tb/tb_fifo_consumer.sv
// Bench for fifo_consumer: queue-based FIFO, cycle model and directed tests.
// Ports: none; drives the DUT through a fifo_consumer_if instance.
module tb_fifo_consumer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  pace = 4'd0;
    logic        stall = 1'b0;
    logic        O_DATA_VALID;
    logic        O_MISMATCH;
    logic [7:0]  O_DATA;
    logic [15:0] RD_COUNT;
    logic [15:0] ERR_COUNT;

    fifo_consumer_if #(.DATA_WIDTH(8)) rd_if ();

    fifo_consumer #(
        .DATA_WIDTH (8),
        .PACE_WIDTH (4),
        .COUNT_WIDTH(16),
        .EXP_INIT   (8'd0)
    ) dut (
        .CON_CLK     (clk),
        .CON_RST     (rst),
        .ENABLE      (enable),
        .PACE        (pace),
        .rd          (rd_if),
        .O_DATA_VALID(O_DATA_VALID),
        .O_DATA      (O_DATA),
        .O_MISMATCH  (O_MISMATCH),
        .RD_COUNT    (RD_COUNT),
        .ERR_COUNT   (ERR_COUNT)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    int         due_q[$];
    logic [7:0] word_q[$];
    int         cyc = 0;
    int         ncmp = 0;
    int         nfail = 0;

    int         rd_total = 0;
    int         mis_total = 0;
    int         run = 0;
    int         max_run = 0;
    int         first_rd = -1;
    int         first_valid = -1;
    logic [7:0] last_mis = 8'd0;
    int         rd_cyc_q[$];

    bit          armed;
    int          cool;
    logic [7:0]  mexp;
    logic [15:0] mrd;
    logic [15:0] merr;
    logic [7:0]  mdata;

    task automatic chk(input string name, input longint act, input longint exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            if (nfail < 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // FIFO read side: one-cycle read latency, empty flag registered
    task automatic fifo_loop();
        logic [7:0] d;
        forever begin
            @(posedge clk);
            if (rd_if.O_RD_EN) begin
                if (fifo.size() == 0) begin
                    chk("underflow", 1, 0);
                end else begin
                    d = fifo.pop_front();
                    rd_if.I_DATA <= d;
                    due_q.push_back(cyc + 2);
                    word_q.push_back(d);
                end
            end
            cyc = cyc + 1;
            rd_if.I_EMPTY <= stall || (fifo.size() == 0);
        end
    endtask

    // Behavioural model: a read may issue once armed with no cooldown left
    task automatic cmp_loop();
        bit         exp_rd;
        bit         evalid;
        bit         emis;
        logic [7:0] w;
        forever begin
            @(negedge clk);
            if (rst) begin
                armed = 0;
                cool  = 0;
                mexp  = 8'd0;
                mrd   = 16'd0;
                merr  = 16'd0;
                mdata = 8'd0;
                due_q.delete();
                word_q.delete();
                run = 0;
                chk("rst_rd_en", rd_if.O_RD_EN, 0);
                chk("rst_valid", O_DATA_VALID, 0);
                chk("rst_data", O_DATA, 0);
                chk("rst_rd_count", RD_COUNT, 0);
                chk("rst_err_count", ERR_COUNT, 0);
            end else begin
                exp_rd = armed && enable && !rd_if.I_EMPTY && (cool == 0);
                chk("rd_en", rd_if.O_RD_EN, exp_rd);
                if (rd_if.O_RD_EN) begin
                    rd_total++;
                    rd_cyc_q.push_back(cyc);
                    run++;
                    if (run > max_run) max_run = run;
                    if (first_rd < 0) first_rd = cyc;
                end else begin
                    run = 0;
                end
                if (!enable) begin
                    armed = 0;
                    cool  = 0;
                end else if (!armed) begin
                    armed = 1;
                end else if (exp_rd) begin
                    cool = int'(pace);
                end else if (cool > 0) begin
                    cool--;
                end
                evalid = 0;
                emis   = 0;
                if (due_q.size() != 0 && due_q[0] == cyc) begin
                    void'(due_q.pop_front());
                    w      = word_q.pop_front();
                    evalid = 1;
                    emis   = (w != mexp);
                    mexp   = w + 8'd1;
                    mrd    = mrd + 16'd1;
                    if (emis && merr != 16'hFFFF) merr = merr + 16'd1;
                    mdata  = w;
                end
                chk("valid", O_DATA_VALID, evalid);
                chk("mismatch", O_MISMATCH, emis);
                chk("data", O_DATA, mdata);
                chk("rd_count", RD_COUNT, mrd);
                chk("err_count", ERR_COUNT, merr);
                if (O_MISMATCH) begin
                    mis_total++;
                    last_mis = O_DATA;
                end
                if (O_DATA_VALID && first_valid < 0) first_valid = cyc;
            end
        end
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((fifo.size() != 0 || due_q.size() != 0) && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", (n < lim), 1);
        cycles(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bit got;
        rd_if.I_EMPTY = 1'b1;
        rd_if.I_DATA  = 8'd0;
        fork
            fifo_loop();
            cmp_loop();
        join_none

        // Reset state
        cycles(2);
        chk("init_rd_en", rd_if.O_RD_EN, 0);
        chk("init_valid", O_DATA_VALID, 0);
        chk("init_rd_count", RD_COUNT, 0);
        chk("init_err_count", ERR_COUNT, 0);
        rst = 1'b0;
        cycles(2);

        // Continuous stream 0..15
        for (int i = 0; i < 16; i++) fifo.push_back(8'(i));
        cycles(2);
        enable = 1'b1;
        drain(100);
        chk("stream_rd_count", RD_COUNT, 16);
        chk("stream_err_count", ERR_COUNT, 0);
        chk("stream_last_data", O_DATA, 15);
        chk("stream_run", max_run, 16);
        chk("stream_latency", first_valid - first_rd, 2);

        // Paced reads, PACE = 3
        rd_cyc_q.delete();
        pace = 4'd3;
        for (int i = 16; i < 20; i++) fifo.push_back(8'(i));
        drain(100);
        chk("paced_reads", rd_cyc_q.size(), 4);
        for (int i = 1; i < 4 && i < rd_cyc_q.size(); i++)
            chk("paced_spacing", rd_cyc_q[i] - rd_cyc_q[i-1], 4);
        chk("paced_rd_count", RD_COUNT, 20);

        // Empty stall for 5 cycles mid-stream
        pace = 4'd0;
        for (int i = 20; i < 30; i++) fifo.push_back(8'(i));
        cycles(3);
        stall = 1'b1;
        cycles(1);
        s = rd_total;
        cycles(4);
        stall = 1'b0;
        cycles(1);
        chk("stall_no_reads", rd_total - s, 0);
        chk("stall_resume", rd_if.O_RD_EN, 1);
        drain(100);
        chk("stall_rd_count", RD_COUNT, 30);
        chk("stall_err_count", ERR_COUNT, 0);

        // ENABLE dropped during WAIT
        pace = 4'd5;
        for (int i = 30; i < 34; i++) fifo.push_back(8'(i));
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = rd_if.O_RD_EN;
        end
        chk("wait_read_seen", got, 1);
        cycles(1);
        cycles(1);
        enable = 1'b0;
        s = rd_total;
        cycles(10);
        chk("disable_no_reads", rd_total - s, 0);
        chk("disable_captured", RD_COUNT, 31);
        pace = 4'd0;
        enable = 1'b1;
        drain(100);
        chk("reenable_rd_count", RD_COUNT, 34);

        // Reset on a read cycle
        for (int i = 34; i < 42; i++) fifo.push_back(8'(i));
        s = rd_total;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            #1;
            got = rd_if.O_RD_EN && (rd_total >= s + 2);
        end
        chk("rst_read_seen", got, 1);
        rst = 1'b1;
        #1;
        chk("async_rd_en", rd_if.O_RD_EN, 0);
        chk("async_valid", O_DATA_VALID, 0);
        chk("async_data", O_DATA, 0);
        chk("async_rd_count", RD_COUNT, 0);
        chk("async_err_count", ERR_COUNT, 0);
        enable = 1'b0;
        fifo.delete();
        cycles(2);
        rst = 1'b0;
        fifo.push_back(8'd0);
        fifo.push_back(8'd1);
        fifo.push_back(8'd2);
        enable = 1'b1;
        drain(100);
        chk("post_rst_rd_count", RD_COUNT, 3);
        chk("post_rst_err_count", ERR_COUNT, 0);
        chk("post_rst_data", O_DATA, 2);

        // I_EMPTY rises as the state enters READ
        enable = 1'b0;
        cycles(2);
        fifo.push_back(8'd3);
        fifo.push_back(8'd4);
        cycles(2);
        enable = 1'b1;
        stall = 1'b1;
        s = rd_total;
        cycles(3);
        chk("enter_empty_no_read", rd_total - s, 0);
        stall = 1'b0;
        drain(100);
        chk("enter_rd_count", RD_COUNT, 5);
        chk("enter_err_count", ERR_COUNT, 0);

        // Wrap 255 -> 0 and a single bad word
        enable = 1'b0;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) fifo.push_back(8'(i));
        fifo.push_back(8'd0);
        fifo.push_back(8'd1);
        fifo.push_back(8'd5);
        fifo.push_back(8'd6);
        cycles(1);
        s = mis_total;
        enable = 1'b1;
        drain(400);
        chk("wrap_rd_count", RD_COUNT, 260);
        chk("wrap_err_count", ERR_COUNT, 1);
        chk("wrap_mis_pulses", mis_total - s, 1);
        chk("wrap_mis_word", last_mis, 5);
        chk("wrap_last_data", O_DATA, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/fifo_consumer.md
Name: fifo_consumer

Overview:
- Consumer-side device on the read port of the asynchronous FIFO. It runs entirely in the CON_CLK domain.
- It drains the FIFO with O_RD_EN while I_EMPTY is low, at a programmable pace, and captures each word returned on I_DATA.
- It checks every captured word against an expected incrementing sequence and keeps read and error counts for the bench and scoreboard.

Parameters:
- DATA_WIDTH, 8, width of the FIFO data word.
- PACE_WIDTH, 4, width of the PACE input (idle cycles between reads).
- COUNT_WIDTH, 16, width of RD_COUNT and ERR_COUNT.
- EXP_INIT, 0, first expected data value after reset.

Ports:
- CON_CLK  input  1  consumer clock. The only clock.
- CON_RST  input  1  asynchronous, active-high reset.
- ENABLE  input  1  allows reads when high.
- PACE  input  PACE_WIDTH  idle cycles inserted after each read.
- I_EMPTY  input  1  FIFO empty flag, already synchronised to CON_CLK.
- I_DATA  input  DATA_WIDTH  FIFO read data, valid the cycle after an O_RD_EN cycle.
- O_RD_EN  output  1  FIFO read strobe.
- O_DATA_VALID  output  1  one-cycle pulse when O_DATA holds a captured word.
- O_DATA  output  DATA_WIDTH  captured word.
- O_MISMATCH  output  1  one-cycle pulse, coincident with O_DATA_VALID, when the word differs from the expected value.
- RD_COUNT  output  COUNT_WIDTH  words captured since reset.
- ERR_COUNT  output  COUNT_WIDTH  mismatches since reset.

Behaviour:
- Reset (asynchronous, CON_RST high):
  - state = IDLE; pace counter = 0; expected value = EXP_INIT.
  - O_RD_EN = 0, O_DATA_VALID = 0, O_DATA = 0, O_MISMATCH = 0, RD_COUNT = 0, ERR_COUNT = 0.
  - The capture pipeline flag is cleared, so a read in flight when reset asserts is discarded.
- States: IDLE, READ, WAIT.
- O_RD_EN = (state == READ) & ENABLE & !I_EMPTY.
  - Combinational from registered state and the I_EMPTY input.
  - Never asserted while I_EMPTY = 1, so the block cannot underflow the FIFO.
- State transitions:
  - IDLE -> READ when ENABLE = 1.
  - READ, O_RD_EN = 1, PACE = 0: stay in READ. Back-to-back reads, one per cycle.
  - READ, O_RD_EN = 1, PACE > 0: go to WAIT and load the pace counter with PACE.
  - READ, O_RD_EN = 0 because I_EMPTY = 1: stay in READ.
  - WAIT: decrement the pace counter each cycle. When it equals 1, go to READ. Read spacing is therefore PACE+1 cycles.
  - ENABLE = 0 in any state: go to IDLE the next cycle. A read already issued in that cycle is still captured.
- PACE is sampled only on the O_RD_EN cycle. Changing PACE during WAIT has no effect on the current wait.
- Capture pipeline:
  - A flag registers O_RD_EN.
  - In the cycle after each O_RD_EN cycle, I_DATA is sampled into O_DATA, registered.
  - O_DATA_VALID pulses one cycle later, so it is high 2 cycles after the O_RD_EN cycle.
  - O_DATA holds its value between captures.
- Checking, applied at each capture:
  - Compare the sampled I_DATA with the expected value.
  - On match: expected = data + 1, modulo 2^DATA_WIDTH.
  - On mismatch: O_MISMATCH pulses with O_DATA_VALID, ERR_COUNT increments, and expected resyncs to data + 1. A single dropped or corrupted word therefore produces exactly one error.
  - Expected value wraps 2^DATA_WIDTH-1 -> 0 with no error.
- Counters:
  - RD_COUNT increments on every O_DATA_VALID and wraps modulo 2^COUNT_WIDTH.
  - ERR_COUNT saturates at all-ones.
- I_EMPTY rising in the same cycle the state enters READ: O_RD_EN stays 0. No read is issued and no error is raised.

Test Plan:
- Reset check: assert CON_RST mid-cycle, asynchronously. All outputs go 0 immediately, state is IDLE, RD_COUNT = ERR_COUNT = 0.
- Continuous stream:
  - Stimulus: FIFO preloaded with 0..15, ENABLE = 1, PACE = 0.
  - Response: O_RD_EN high for 16 consecutive cycles. O_DATA_VALID for 16 cycles starting 2 cycles after the first O_RD_EN, O_DATA = 0..15. RD_COUNT = 16, ERR_COUNT = 0.
- Paced reads:
  - Stimulus: PACE = 3, FIFO holds 0..3.
  - Response: O_RD_EN pulses at cycles t, t+4, t+8, t+12. Four valid words, no errors.
- Empty stall and resume: I_EMPTY = 1 for 5 cycles mid-stream -> O_RD_EN = 0 throughout, no spurious O_DATA_VALID. Reading resumes on the first cycle I_EMPTY = 0.
- Mismatch and wrap:
  - Stimulus: feed 254, 255, 0, 1, 5, 6 with EXP_INIT = 254.
  - Response: one O_MISMATCH, on word 5. ERR_COUNT = 1. The 255 -> 0 wrap raises no error, and 6 matches after the resync.
- Reset and ENABLE mid-operation:
  - CON_RST asserted on an O_RD_EN cycle: the in-flight word is never reported and the expected value returns to EXP_INIT.
  - ENABLE deasserted during WAIT: IDLE next cycle, no further O_RD_EN.
